// File: rtl/light_system.sv
// light_system: smart-room lamp controller, Moore FSM with an idle-occupancy auto-off timer.
module light_system #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic StartOn,
  input  logic StartOff,
  input  logic keypad,
  input  logic state,
  output logic initialize,
  output logic lamp_on,
  output logic lamp_off,
  output logic start_on_turn_on_button,
  output logic start_on_turn_off_button,
  output logic timingpass,
  output logic lamp_stays_off,
  output logic lampstate
);
  typedef enum logic [2:0] {INIT, LAMP_OFF, ON_REQ, LAMP_ON, OFF_REQ, TIMED_OUT, STAY_OFF} fsm_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
  fsm_t fsm, nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic expired;
  // >= keeps a counter carried back from OFF_REQ past TIMEOUT-1 from escaping the timeout
  assign expired = !state && cnt >= LAST;
  always_comb begin
    nxt = fsm;
    cnt_nxt = '0;
    case (fsm)
      INIT:               nxt = LAMP_OFF;
      LAMP_OFF, STAY_OFF: nxt = StartOn ? ON_REQ : fsm;
      ON_REQ:             nxt = keypad ? LAMP_ON : !StartOn ? LAMP_OFF : ON_REQ;
      LAMP_ON: begin
        nxt = StartOff ? OFF_REQ : expired ? TIMED_OUT : LAMP_ON;
        cnt_nxt = state ? '0 : &cnt ? cnt : cnt + CNT_W'(1);
      end
      OFF_REQ: begin
        nxt = keypad ? LAMP_OFF : !StartOff ? LAMP_ON : OFF_REQ;
        cnt_nxt = cnt;
      end
      TIMED_OUT:          nxt = STAY_OFF;
      default:            nxt = INIT;
    endcase
  end
  // status flops are loaded from the next state so they always mirror fsm
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm <= INIT;
      cnt <= '0;
      initialize <= 1'b1;
      lamp_on <= 1'b0;
      lamp_off <= 1'b0;
      start_on_turn_on_button <= 1'b0;
      start_on_turn_off_button <= 1'b0;
      timingpass <= 1'b0;
      lamp_stays_off <= 1'b0;
      lampstate <= 1'b0;
    end else begin
      fsm <= nxt;
      cnt <= cnt_nxt;
      initialize <= nxt == INIT;
      lamp_on <= nxt == LAMP_ON;
      lamp_off <= nxt == LAMP_OFF;
      start_on_turn_on_button <= nxt == ON_REQ;
      start_on_turn_off_button <= nxt == OFF_REQ;
      timingpass <= nxt == TIMED_OUT;
      lamp_stays_off <= nxt == STAY_OFF;
      lampstate <= nxt == LAMP_ON || nxt == OFF_REQ;
    end
  end
endmodule

// File: tb/tb_light_system.sv
// tb_light_system: scoreboard bench for light_system against a rule-level lamp model.
module tb_light_system;
  localparam int TIMEOUT = 16;
  logic clk = 0, reset = 1, start_on = 0, start_off = 0, keypad = 0, occ = 0;
  logic initialize, lamp_on, lamp_off, req_on, req_off, timingpass, stays_off, lampstate;
  logic [7:0] got;
  always #5 clk = ~clk;
  light_system #(.TIMEOUT(TIMEOUT), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .StartOn(start_on), .StartOff(start_off), .keypad(keypad), .state(occ),
    .initialize(initialize), .lamp_on(lamp_on), .lamp_off(lamp_off),
    .start_on_turn_on_button(req_on), .start_on_turn_off_button(req_off),
    .timingpass(timingpass), .lamp_stays_off(stays_off), .lampstate(lampstate)
  );
  assign got = {initialize, lamp_on, lamp_off, req_on, req_off, timingpass, stays_off, lampstate};
  typedef enum int {M_INIT, M_OFF, M_ONREQ, M_ON, M_OFFREQ, M_TOUT, M_STAY} mode_t;
  mode_t mode = M_INIT;
  int empty_run = 0;
  logic [7:0] exp_q[$];
  int n_checks = 0, n_fail = 0;
  function automatic logic [7:0] expect_of(mode_t m);
    return {m == M_INIT, m == M_ON, m == M_OFF, m == M_ONREQ, m == M_OFFREQ, m == M_TOUT, m == M_STAY,
            m == M_ON || m == M_OFFREQ};
  endfunction
  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask
  // empty_run counts consecutive empty-room edges spent with the lamp lit
  function automatic void model_step(bit on, bit off, bit kp, bit o);
    int run;
    case (mode)
      M_INIT: mode = M_OFF;
      M_OFF, M_STAY: if (on) mode = M_ONREQ;
      M_ONREQ: if (kp) begin mode = M_ON; empty_run = 0; end else if (!on) mode = M_OFF;
      M_ON: begin
        run = o ? 0 : empty_run + 1;
        if (off) mode = M_OFFREQ;
        else if (run >= TIMEOUT) mode = M_TOUT;
        empty_run = run;
      end
      M_OFFREQ: if (kp) mode = M_OFF; else if (!off) mode = M_ON;
      M_TOUT: mode = M_STAY;
      default: mode = M_INIT;
    endcase
  endfunction
  task automatic drive(bit on, bit off, bit kp, bit o);
    @(negedge clk);
    start_on = on; start_off = off; keypad = kp; occ = o;
    model_step(on, off, kp, o);
    exp_q.push_back(expect_of(mode));
  endtask
  task automatic reset_pulse(bit on, bit off, bit kp, bit o);
    @(negedge clk);
    start_on = on; start_off = off; keypad = kp; occ = o;
    #1 reset = 1;
    #1 check("async_reset", got, expect_of(M_INIT));
    #1 reset = 0;
    #1 check("init_after_release", got, expect_of(M_INIT));
    mode = M_INIT;
    empty_run = 0;
    model_step(on, off, kp, o);
    exp_q.push_back(expect_of(mode));
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) check("outputs", got, exp_q.pop_front());
  end
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    reset_pulse(0, 0, 0, 0);
    drive(1, 0, 0, 0); drive(0, 0, 0, 0);
    drive(1, 0, 0, 0); drive(0, 0, 1, 0);
    repeat (TIMEOUT) drive(0, 0, 0, 0);
    drive(0, 0, 0, 1); drive(0, 0, 1, 1);
    drive(1, 0, 1, 0); drive(1, 0, 1, 0);
    repeat (9) drive(0, 0, 0, 0);
    drive(0, 0, 0, 1);
    repeat (TIMEOUT) drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(1, 0, 0, 0); drive(0, 0, 1, 0);
    repeat (TIMEOUT - 1) drive(0, 0, 0, 0);
    drive(1, 1, 0, 0); drive(0, 0, 0, 0);
    drive(0, 1, 0, 0); drive(0, 1, 1, 0);
    drive(1, 0, 1, 0); drive(1, 0, 1, 0);
    repeat (7) drive(0, 0, 0, 0);
    reset_pulse(0, 0, 0, 0);
    drive(1, 0, 1, 0); drive(1, 0, 1, 0);
    repeat (TIMEOUT + 1) drive(0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      bit idle;
      bit on, off, kp, o;
      idle = ((i / 300) % 2) == 1;
      on  = $urandom_range(0, 99) < (idle ? 40 : 30);
      off = $urandom_range(0, 99) < (idle ? 3 : 30);
      kp  = $urandom_range(0, 99) < (idle ? 50 : 30);
      o   = $urandom_range(0, 99) < (idle ? 5 : 50);
      if ($urandom_range(0, 199) == 0) reset_pulse(on, off, kp, o);
      else drive(on, off, kp, o);
    end
    @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
